lsu_mem_stage: RTL

- Memory stage directly downstream of the execute stage: takes the ALU result (effective address or plain result), store data and load/store controls, performs at most one data-memory access per instruction over a request/grant/response bus, and hands a single result to write-back.
- Handles byte/half/word alignment, write masks, load sign/zero extension, misalignment and illegal-op detection, and a bus timeout.
- Valid/ready handshakes on both sides.

---
 rtl/lsu_mem_stage_pkg.sv | 32 +++
 rtl/lsu_mem_stage_if.sv | 49 ++++
 rtl/lsu_data_align.sv | 62 ++++++
 rtl/lsu_mem_stage.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/lsu_mem_stage_pkg.sv
// rtl/lsu_mem_stage_pkg.sv - shared types, funct3 codes and legality check for the LSU memory stage
//
// Purpose: common definitions imported by lsu_mem_stage, lsu_data_align and the interface users.
// Contents: funct3 access codes, FSM state encoding, op_legal() ren/wen/funct3 check.

package lsu_mem_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Non-memory ops (neither ren nor wen) are always legal; ren & wen together never are.
  function automatic logic op_legal(input logic ren, input logic wen, input logic [2:0] funct3);
    if (ren && wen) return 1'b0;
    if (ren) return funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    if (wen) return funct3 inside {F3_SB, F3_SH, F3_SW};
    return 1'b1;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// rtl/lsu_mem_stage_if.sv - execute/bus/write-back signal bundle for the LSU memory stage
//
// Purpose: groups the upstream handshake, data-memory bus and write-back handshake.
// Ports (master = the stage):
//   upstream  : in_valid_i, in_ready_o, alu_out_i, store_data_i, mem_ren_i, mem_wen_i,
//               funct3_i, rd_addr_i, rd_wen_i
//   mem bus   : mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
//               mem_gnt_i, mem_rvalid_i, mem_rdata_i
//   write-back: out_valid_o, out_ready_i, result_o, rd_addr_o, rd_wen_o, err_o

interface lsu_mem_stage_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] alu_out_i;
  logic [31:0] store_data_i;
  logic        mem_ren_i;
  logic        mem_wen_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_addr_i;
  logic        rd_wen_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;
  logic        rd_wen_o;
  logic        err_o;

  modport master (
    input  in_valid_i, alu_out_i, store_data_i, mem_ren_i, mem_wen_i, funct3_i,
           rd_addr_i, rd_wen_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, out_ready_i,
    output in_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
           out_valid_o, result_o, rd_addr_o, rd_wen_o, err_o
  );

  modport slave (
    output in_valid_i, alu_out_i, store_data_i, mem_ren_i, mem_wen_i, funct3_i,
           rd_addr_i, rd_wen_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, out_ready_i,
    input  in_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
           out_valid_o, result_o, rd_addr_o, rd_wen_o, err_o
  );
endinterface

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - combinational lane alignment, masks, legality and load extension
//
// Purpose: byte-lane steering for stores, sign/zero extension for loads, error flags.
// Ports:
//   addr_lo, funct3, ren, wen, store_data, rdata : access description and raw data
//   wmask, wdata                                 : lane-shifted store enables/data
//   misaligned, illegal                          : access error flags
//   load_data                                    : extracted and extended load result

module lsu_data_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic        illegal,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    illegal    = !op_legal(ren, wen, funct3);
    misaligned = 1'b0;
    if (ren || wen) begin
      // funct3[1:0] carries the access size for both loads and stores.
      case (funct3[1:0])
        2'b01:   misaligned = addr_lo[0];
        2'b10:   misaligned = (addr_lo != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end

    wmask = 4'b0000;
    if (wen) begin
      case (funct3)
        F3_SB:   wmask = 4'b0001 << addr_lo;
        F3_SH:   wmask = 4'b0011 << addr_lo;
        F3_SW:   wmask = 4'b1111;
        default: wmask = 4'b0000;
      endcase
    end
    wdata = store_data << {addr_lo, 3'b000};

    shifted = rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LW:   load_data = rdata;
      F3_LBU:  load_data = {24'h0, shifted[7:0]};
      F3_LHU:  load_data = {16'h0, shifted[15:0]};
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - memory stage: one bus access per instruction, result to write-back
//
// Purpose: registers the execute-stage instruction, issues at most one request/grant/response
// access, applies alignment and extension, detects errors and bus timeouts.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : lsu_mem_stage_if.master (upstream handshake, memory bus, write-back handshake)

module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_mem_stage_if.master   bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, result_q;
  logic [3:0]            wmask_q;
  logic                  we_q, rd_wen_q, err_q;
  logic [1:0]            lo_q;
  logic [2:0]            f3_q;
  logic [4:0]            rd_q;

  logic [1:0]  align_lo;
  logic [2:0]  align_f3;
  logic [3:0]  wmask;
  logic [31:0] wdata, load_data;
  logic        misaligned, illegal, is_mem, go_req, timeout;

  // In IDLE the aligner looks at the incoming instruction; afterwards it looks at
  // the registered one so load extension uses the accepted address and funct3.
  assign align_lo = (state_q == S_IDLE) ? bus.alu_out_i[1:0] : lo_q;
  assign align_f3 = (state_q == S_IDLE) ? bus.funct3_i       : f3_q;

  lsu_data_align u_align (
    .addr_lo    (align_lo),
    .funct3     (align_f3),
    .ren        (bus.mem_ren_i),
    .wen        (bus.mem_wen_i),
    .store_data (bus.store_data_i),
    .rdata      (bus.mem_rdata_i),
    .wmask      (wmask),
    .wdata      (wdata),
    .misaligned (misaligned),
    .illegal    (illegal),
    .load_data  (load_data)
  );

  assign is_mem  = bus.mem_ren_i | bus.mem_wen_i;
  assign go_req  = is_mem & ~illegal & ~misaligned;
  // Counter starts at 0 on entering REQ, so reaching TIMEOUT_CYCLES-1 here means
  // TIMEOUT_CYCLES cycles have been spent in REQ/WAIT.
  assign timeout = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.in_valid_i) state_d = go_req ? S_REQ : S_DONE;
      S_REQ: begin
        if (bus.mem_gnt_i)  state_d = S_WAIT;
        else if (timeout)   state_d = S_DONE;
      end
      S_WAIT: if (bus.mem_rvalid_i || timeout) state_d = S_DONE;
      S_DONE: if (bus.out_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
      wmask_q  <= '0;
      we_q     <= 1'b0;
      rd_wen_q <= 1'b0;
      err_q    <= 1'b0;
      lo_q     <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid_i) begin
            cnt_q    <= '0;
            lo_q     <= bus.alu_out_i[1:0];
            f3_q     <= bus.funct3_i;
            rd_q     <= bus.rd_addr_i;
            err_q    <= is_mem & ~go_req;
            rd_wen_q <= bus.rd_wen_i & ~(is_mem & ~go_req);
            result_q <= is_mem ? '0 : bus.alu_out_i;
            // Bus fields only carry the access when one will actually be issued.
            addr_q   <= go_req ? {bus.alu_out_i[31:2], 2'b00} : '0;
            wdata_q  <= (go_req & bus.mem_wen_i) ? wdata : '0;
            wmask_q  <= go_req ? wmask : 4'b0000;
            we_q     <= go_req & bus.mem_wen_i;
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (!bus.mem_gnt_i && timeout) begin
            err_q    <= 1'b1;
            rd_wen_q <= 1'b0;
            result_q <= '0;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.mem_rvalid_i) begin
            result_q <= we_q ? '0 : load_data;
          end else if (timeout) begin
            err_q    <= 1'b1;
            rd_wen_q <= 1'b0;
            result_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready_o  = (state_q == S_IDLE);
  assign bus.mem_req_o   = (state_q == S_REQ);
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_wmask_o = wmask_q;
  assign bus.out_valid_o = (state_q == S_DONE);
  assign bus.result_o    = result_q;
  assign bus.rd_addr_o   = rd_q;
  assign bus.rd_wen_o    = rd_wen_q;
  assign bus.err_o       = err_q;

endmodule
